// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO read and write controllers.
package sync_fifo_pkg;

    // Default pointer width (capacity is 2^FIFO_AW-1 entries) and data width.
    localparam int FIFO_AW = 7;
    localparam int FIFO_DW = 32;

    // Pointer and data types for default-width instances.
    typedef logic [FIFO_AW-1:0] ptr_t;
    typedef logic [FIFO_DW-1:0] data_t;

endpackage

// File: rtl/sync_fifo_rdout.sv
// Read output stage: remembers that a memory read was issued last cycle and
// captures the memory's registered data into rdata_o with a one-cycle valid.
module sync_fifo_rdout
    import sync_fifo_pkg::*;
#(
    parameter int DW = FIFO_DW
) (
    input  logic          rclk_i,
    input  logic          rst_n,
    input  logic          strobe_i,
    input  logic [DW-1:0] rdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          rvalid_o
);

    logic          pending_q;
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;

    // Track the in-flight read and capture memory data one cycle after the strobe.
    always_ff @(posedge rclk_i or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            pending_q <= strobe_i;
            rvalid_q  <= pending_q;
            if (pending_q) begin
                rdata_q <= rdata_i;
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/sync_fifo_rdctrl.sv
// Read-side controller of a single-clock FIFO: owns the read pointer, derives
// occupancy/empty flags from the write pointer, issues the memory read strobe,
// and records reads attempted while empty.
module sync_fifo_rdctrl
    import sync_fifo_pkg::*;
#(
    parameter int          AW     = FIFO_AW,
    parameter int          DW     = FIFO_DW,
    parameter int unsigned AE_LVL = 4
) (
    input  logic          rclk_i,
    input  logic          rst_n,
    input  logic          renable,
    input  logic [AW-1:0] wpnt_i,
    input  logic [DW-1:0] rdata_i,
    input  logic          uflow_clr_i,
    output logic          renable_o,
    output logic [AW-1:0] rpnt_o,
    output logic [DW-1:0] rdata_o,
    output logic          rvalid_o,
    output logic          empty_o,
    output logic          aempty_o,
    output logic [AW-1:0] level_o,
    output logic          uflow_o
);

    logic [AW-1:0] rpnt_q, rpnt_d;
    logic          uflow_q, uflow_d;

    // Flags come straight from the pointers so a write is visible the next cycle.
    assign empty_o   = (rpnt_q == wpnt_i);
    assign level_o   = wpnt_i - rpnt_q;
    assign aempty_o  = (32'(level_o) <= AE_LVL);
    assign renable_o = rst_n & renable & ~empty_o;
    assign rpnt_o    = rpnt_q;
    assign uflow_o   = uflow_q;

    // Next-state for the read pointer and the sticky underflow flag.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        rpnt_d  = rpnt_q;
        uflow_d = uflow_q;
        if (renable_o) begin
            rpnt_d = rpnt_q + AW'(1);
        end
        // A refused read outranks a clear issued in the same cycle.
        if (renable && empty_o) begin
            uflow_d = 1'b1;
        end else if (uflow_clr_i) begin
            uflow_d = 1'b0;
        end
    end

    // Pointer and underflow state registers.
    always_ff @(posedge rclk_i or negedge rst_n) begin
        if (!rst_n) begin
            rpnt_q  <= '0;
            uflow_q <= 1'b0;
        end else begin
            rpnt_q  <= rpnt_d;
            uflow_q <= uflow_d;
        end
    end

    sync_fifo_rdout #(
        .DW(DW)
    ) u_rdout (
        .rclk_i  (rclk_i),
        .rst_n   (rst_n),
        .strobe_i(renable_o),
        .rdata_i (rdata_i),
        .rdata_o (rdata_o),
        .rvalid_o(rvalid_o)
    );

endmodule

// File: tb/tb_sync_fifo_rdctrl.sv
// Self-checking bench for sync_fifo_rdctrl (AW=3, DW=8, AE_LVL=2): a queue
// model of FIFO contents plus a list of due read returns, compared each cycle.
module tb_sync_fifo_rdctrl;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int AE = 2;
    localparam int CAP = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          renable;
    logic [AW-1:0] wpnt_i;
    logic [DW-1:0] rdata_i;
    logic          uflow_clr_i;
    logic          renable_o;
    logic [AW-1:0] rpnt_o;
    logic [DW-1:0] rdata_o;
    logic          rvalid_o;
    logic          empty_o;
    logic          aempty_o;
    logic [AW-1:0] level_o;
    logic          uflow_o;

    always #5 clk = ~clk;

    sync_fifo_rdctrl #(.AW(AW), .DW(DW), .AE_LVL(AE)) dut (
        .rclk_i     (clk),
        .rst_n      (rst_n),
        .renable    (renable),
        .wpnt_i     (wpnt_i),
        .rdata_i    (rdata_i),
        .uflow_clr_i(uflow_clr_i),
        .renable_o  (renable_o),
        .rpnt_o     (rpnt_o),
        .rdata_o    (rdata_o),
        .rvalid_o   (rvalid_o),
        .empty_o    (empty_o),
        .aempty_o   (aempty_o),
        .level_o    (level_o),
        .uflow_o    (uflow_o)
    );

    // Memory with registered read; garbage on rdata_i when no read was issued.
    logic [DW-1:0] mem [1 << AW];
    always @(posedge clk) begin
        if (renable_o) rdata_i <= mem[rpnt_o];
        else           rdata_i <= DW'($urandom);
    end

    // Behavioural model state.
    typedef struct { int due; logic [DW-1:0] word; } ret_t;
    logic [DW-1:0] q[$];
    ret_t          rets[$];
    int            reads;
    bit            uflow_m;
    logic [DW-1:0] last_word;
    int            cyc;
    logic          wr_req;
    logic [DW-1:0] wr_word;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : cmp
        logic          exp_v;
        logic [DW-1:0] exp_d;
        if (rst_n === 1'b1) begin
            exp_v = 1'b0;
            exp_d = last_word;
            if (rets.size() > 0 && rets[0].due == cyc) begin
                exp_v     = 1'b1;
                exp_d     = rets[0].word;
                last_word = rets[0].word;
                void'(rets.pop_front());
            end
            check("renable_o", 32'(renable_o), 32'(renable && q.size() != 0));
            check("rpnt_o",    32'(rpnt_o),    32'(reads % (1 << AW)));
            check("empty_o",   32'(empty_o),   32'(q.size() == 0));
            check("level_o",   32'(level_o),   32'(q.size()));
            check("aempty_o",  32'(aempty_o),  32'(q.size() <= AE));
            check("uflow_o",   32'(uflow_o),   32'(uflow_m));
            check("rvalid_o",  32'(rvalid_o),  32'(exp_v));
            check("rdata_o",   32'(rdata_o),   32'(exp_d));
        end
    end

    task automatic drive(input logic ren, input logic wr, input logic clr, input logic [DW-1:0] w);
        renable     = ren;
        wr_req      = wr;
        uflow_clr_i = clr;
        wr_word     = w;
    endtask

    // Advance one clock edge: update the model from this cycle's inputs, then
    // perform the producer's write just after the edge.
    task automatic tick();
        bit            granted;
        bit            wrote;
        logic [DW-1:0] w;
        @(posedge clk);
        granted = renable && q.size() != 0;
        wrote   = wr_req && q.size() < CAP;
        if (renable && q.size() == 0) uflow_m = 1'b1;
        else if (uflow_clr_i)         uflow_m = 1'b0;
        if (granted) begin
            w = q.pop_front();
            rets.push_back('{cyc + 2, w});
            reads++;
        end
        if (wrote) q.push_back(wr_word);
        cyc++;
        #1;
        if (wrote) begin
            mem[wpnt_i] = wr_word;
            wpnt_i      = wpnt_i + AW'(1);
        end
    endtask

    task automatic cycle(input logic ren, input logic wr, input logic clr, input logic [DW-1:0] w);
        drive(ren, wr, clr, w);
        @(negedge clk);
        tick();
    endtask

    task automatic model_clear();
        q.delete();
        rets.delete();
        reads     = 0;
        uflow_m   = 1'b0;
        last_word = '0;
    endtask

    // Reset asserted just after an edge, held across one edge, released just after the next.
    task automatic reset_pulse();
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_renable_o", 32'(renable_o), 32'(0));
        check("rst_rvalid_o",  32'(rvalid_o),  32'(0));
        check("rst_rdata_o",   32'(rdata_o),   32'(0));
        @(posedge clk);
        #1;
        wpnt_i = '0;
        drive(1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        cyc    = 0;
        wpnt_i = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        drive(1'b0, 1'b0, 1'b0, '0);
        model_clear();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;

        // Read on empty: refused, sticky underflow, then cleared.
        drive(1, 0, 0, 0); @(negedge clk);
        check("lit_empty_ren_o", 32'(renable_o), 0);
        check("lit_empty_flag",  32'(empty_o),   1);
        check("lit_uflow_pre",   32'(uflow_o),   0);
        tick();
        drive(0, 0, 1, 0); @(negedge clk);
        check("lit_uflow_set",   32'(uflow_o),   1);
        tick();
        drive(0, 0, 0, 0); @(negedge clk);
        check("lit_uflow_clr",   32'(uflow_o),   0);
        tick();

        // Three writes, three back-to-back reads, words return in order.
        cycle(0, 1, 0, 8'hA1);
        cycle(0, 1, 0, 8'hA2);
        cycle(0, 1, 0, 8'hA3);
        drive(1, 0, 0, 0); @(negedge clk);
        check("lit_rpnt0",  32'(rpnt_o), 0);
        check("lit_level3", 32'(level_o), 3);
        tick();
        drive(1, 0, 0, 0); @(negedge clk);
        check("lit_rpnt1",  32'(rpnt_o), 1);
        check("lit_rv_n1",  32'(rvalid_o), 0);
        tick();
        drive(1, 0, 0, 0); @(negedge clk);
        check("lit_rpnt2",  32'(rpnt_o), 2);
        check("lit_rv_n2",  32'(rvalid_o), 1);
        check("lit_d_n2",   32'(rdata_o), 32'hA1);
        tick();
        drive(0, 0, 0, 0); @(negedge clk);
        check("lit_rpnt3",  32'(rpnt_o), 3);
        check("lit_empty3", 32'(empty_o), 1);
        check("lit_d_n3",   32'(rdata_o), 32'hA2);
        tick();
        drive(0, 0, 0, 0); @(negedge clk);
        check("lit_rv_n4",  32'(rvalid_o), 1);
        check("lit_d_n4",   32'(rdata_o), 32'hA3);
        tick();
        drive(0, 0, 0, 0); @(negedge clk);
        check("lit_rv_n5",  32'(rvalid_o), 0);
        check("lit_d_hold", 32'(rdata_o), 32'hA3);
        tick();

        // Walk pointers to rpnt=7, wpnt=1, then read across the wrap.
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, DW'($urandom));
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 8'hB1);
        cycle(0, 1, 0, 8'hB2);
        drive(1, 0, 0, 0); @(negedge clk);
        check("lit_wrap_rp7",  32'(rpnt_o), 7);
        check("lit_wrap_lv2",  32'(level_o), 2);
        check("lit_wrap_ae2",  32'(aempty_o), 1);
        tick();
        drive(1, 0, 0, 0); @(negedge clk);
        check("lit_wrap_rp0",  32'(rpnt_o), 0);
        check("lit_wrap_lv1",  32'(level_o), 1);
        tick();
        drive(0, 0, 0, 0); @(negedge clk);
        check("lit_wrap_rp1",  32'(rpnt_o), 1);
        check("lit_wrap_lv0",  32'(level_o), 0);
        check("lit_wrap_ae0",  32'(aempty_o), 1);
        tick();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

        // Read and write together while empty: read refused, underflow flagged.
        drive(1, 1, 0, 8'h5C); @(negedge clk);
        check("lit_rw_empty_ren", 32'(renable_o), 0);
        tick();
        drive(0, 0, 0, 0); @(negedge clk);
        check("lit_rw_empty_uf", 32'(uflow_o), 1);
        check("lit_rw_empty_lv", 32'(level_o), 1);
        tick();

        // Read and write together at level 1: read granted, not empty after.
        drive(1, 1, 0, 8'h6D); @(negedge clk);
        check("lit_rw_lv1_ren", 32'(renable_o), 1);
        tick();
        drive(0, 0, 1, 0); @(negedge clk);
        check("lit_rw_lv1_emp", 32'(empty_o), 0);
        check("lit_rw_lv1_lv",  32'(level_o), 1);
        tick();
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0);

        // Strobe, then reset one cycle later: the in-flight read must vanish.
        cycle(1, 0, 0, 0);
        renable = 1'b1;
        reset_pulse();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0); @(negedge clk);
            check("lit_post_rst_rv", 32'(rvalid_o), 0);
            check("lit_post_rst_d",  32'(rdata_o),  0);
            tick();
        end

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                reset_pulse();
            end else begin
                cycle(logic'($urandom_range(0, 99) < 55),
                      logic'($urandom_range(0, 99) < 50),
                      logic'($urandom_range(0, 99) < 10),
                      DW'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
